// File: rtl/ama_riscv_store_shift_mask_pkg.sv
// Shared types and helpers for the DMEM store path.
package ama_riscv_store_shift_mask_pkg;

    // Access width encoded in funct3[1:0]; 2'b11 is reserved.
    typedef enum logic [1:0] {
        DMEM_DTYPE_BYTE = 2'd0,
        DMEM_DTYPE_HALF = 2'd1,
        DMEM_DTYPE_WORD = 2'd2
    } dmem_dtype_t;

    // One buffered DMEM write: word address, byte strobe, lane-replicated data.
    typedef struct packed {
        logic [29:0] addr_w;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } store_entry_t;

    // Byte enables for an aligned store of the given width at the given byte offset.
    function automatic logic [3:0] store_wstrb(input logic [1:0] width, input logic [1:0] off);
        logic [3:0] strb;
        case (width)
            DMEM_DTYPE_BYTE: strb = 4'b0001 << off;
            DMEM_DTYPE_HALF: strb = 4'b0011 << off;
            DMEM_DTYPE_WORD: strb = 4'b1111;
            default:         strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/ama_riscv_sync_fifo.sv
// Generic synchronous FIFO with valid/ready on both sides and a registered count.
module ama_riscv_sync_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  T                         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output T                         out_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    T              mem_q [DEPTH];

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    // Gate the head entry so the outputs read zero whenever the FIFO is empty.
    assign out_data  = out_valid ? mem_q[head_q] : '0;
    assign count     = count_q;

    // Next-state pointers and occupancy from the two handshakes.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        push    = in_valid && in_ready;
        pop     = out_valid && out_ready;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + 1'b1;
        if (pop)  head_d = head_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // Pointer and count registers, cleared by reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the count gates validity and out_data masks stale entries.
        if (push) mem_q[tail_q] <= in_data;
    end

endmodule

// File: rtl/ama_riscv_store_shift_mask.sv
// Store path: alignment check, shift/mask into DMEM lanes, buffering FIFO, misalign report.
module ama_riscv_store_shift_mask
    import ama_riscv_store_shift_mask_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_width,
    input  logic [31:0] req_data,
    output logic        dmem_valid,
    input  logic        dmem_ready,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    output logic        misalign,
    output logic [31:0] misalign_addr,
    output logic        pending
);
    logic [1:0]              off;
    logic [1:0]              width;
    logic                    misaligned;
    logic                    req_fire;
    logic                    fifo_in_ready;
    logic [$clog2(DEPTH):0]  fifo_count;
    store_entry_t            entry;
    store_entry_t            head;
    logic                    misalign_q, misalign_d;
    logic [31:0]             misalign_addr_q, misalign_addr_d;
    logic                    unused_width_msb;

    // funct3[2] only selects sign extension on loads.
    assign unused_width_msb = req_width[2];

    assign off       = req_addr[1:0];
    assign width     = req_width[1:0];
    assign req_ready = fifo_in_ready && !rst;
    assign req_fire  = req_valid && req_ready;

    // Alignment check and lane replication of the store data.
    always_comb begin
        misaligned   = 1'b1;
        entry        = '0;
        entry.addr_w = req_addr[31:2];
        entry.wstrb  = store_wstrb(width, off);
        case (width)
            DMEM_DTYPE_BYTE: begin
                misaligned  = 1'b0;
                entry.wdata = {4{req_data[7:0]}};
            end
            DMEM_DTYPE_HALF: begin
                misaligned  = off[0];
                entry.wdata = {2{req_data[15:0]}};
            end
            DMEM_DTYPE_WORD: begin
                misaligned  = (off != 2'b00);
                entry.wdata = req_data;
            end
            default: begin
                misaligned  = 1'b1;
                entry.wdata = req_data;
            end
        endcase
    end

    ama_riscv_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (store_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (req_valid && !misaligned && !rst),
        .in_ready  (fifo_in_ready),
        .in_data   (entry),
        .out_valid (dmem_valid),
        .out_ready (dmem_ready),
        .out_data  (head),
        .count     (fifo_count)
    );

    assign dmem_addr  = {head.addr_w, 2'b00};
    assign dmem_wstrb = head.wstrb;
    assign dmem_wdata = head.wdata;
    assign pending    = (fifo_count != '0);

    // Misalign pulse and held address of the last rejected request.
    always_comb begin
        misalign_d      = req_fire && misaligned;
        misalign_addr_d = misalign_addr_q;
        if (req_fire && misaligned) misalign_addr_d = req_addr;
    end

    // Misalign report registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_ama_riscv_store_shift_mask.sv
// Self-checking bench for the store shift/mask block with a queue-based reference model.
module tb_ama_riscv_store_shift_mask;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_width = '0;
    logic [31:0] req_data = '0;
    logic        dmem_valid;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        misalign;
    logic [31:0] misalign_addr;
    logic        pending;

    int          checks = 0;
    int          failures = 0;
    wr_t         q[$];
    logic        exp_mis = 1'b0;
    logic [31:0] exp_mis_addr = '0;
    bit          last_accept;

    always #5 clk = ~clk;

    ama_riscv_store_shift_mask #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_width     (req_width),
        .req_data      (req_data),
        .dmem_valid    (dmem_valid),
        .dmem_ready    (dmem_ready),
        .dmem_addr     (dmem_addr),
        .dmem_wstrb    (dmem_wstrb),
        .dmem_wdata    (dmem_wdata),
        .misalign      (misalign),
        .misalign_addr (misalign_addr),
        .pending       (pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: a store of 2^w bytes covers lanes off..off+size-1; lane i carries data byte (i mod size).
    task automatic ref_store(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d,
                             output bit mis, output wr_t e);
        int size;
        int off;
        size   = 1 << w[1:0];
        off    = int'(a[1:0]);
        mis    = (w[1:0] == 2'b11) || ((off % size) != 0);
        e.addr = a & ~32'h3;
        e.strb = '0;
        e.data = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + size) e.strb[i] = 1'b1;
            e.data[8*i +: 8] = d[8*(i % size) +: 8];
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [2:0] w, input logic [31:0] d);
        req_valid = v;
        req_addr  = a;
        req_width = w;
        req_data  = d;
    endtask

    // One clock: check req_ready and advance the model before the edge, check registered outputs after it.
    task automatic cycle();
        wr_t e;
        bit  mis;
        bit  fire_in;
        bit  fire_out;
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(!rst && (q.size() < DEPTH)));
        last_accept = 0;
        if (rst) begin
            q.delete();
            exp_mis      = 1'b0;
            exp_mis_addr = '0;
        end else begin
            fire_in  = req_valid && (q.size() < DEPTH);
            fire_out = dmem_ready && (q.size() > 0);
            ref_store(req_addr, req_width, req_data, mis, e);
            if (fire_out) void'(q.pop_front());
            exp_mis = fire_in && mis;
            if (fire_in && mis) exp_mis_addr = req_addr;
            if (fire_in && !mis) q.push_back(e);
            last_accept = fire_in;
        end
        @(posedge clk);
        #1;
        check("dmem_valid", 32'(dmem_valid), 32'(q.size() > 0));
        check("pending", 32'(pending), 32'(q.size() > 0));
        check("dmem_addr", dmem_addr, (q.size() > 0) ? q[0].addr : 32'h0);
        check("dmem_wstrb", 32'(dmem_wstrb), (q.size() > 0) ? 32'(q[0].strb) : 32'h0);
        check("dmem_wdata", dmem_wdata, (q.size() > 0) ? q[0].data : 32'h0);
        check("misalign", 32'(misalign), 32'(exp_mis));
        check("misalign_addr", misalign_addr, exp_mis_addr);
        check("fifo_count", 32'(dut.fifo_count), 32'(q.size()));
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        cycle();
        cycle();
        check("reset_dmem_valid", 32'(dmem_valid), 32'h0);
        rst = 1'b0;

        // Byte store at offset 3.
        dmem_ready = 1'b0;
        drive(1'b1, 32'h0000_1003, 3'd0, 32'hAABB_CC5A);
        cycle();
        drive(1'b0, '0, '0, '0);
        check("byte_addr", dmem_addr, 32'h0000_1000);
        check("byte_wstrb", 32'(dmem_wstrb), 32'h8);
        check("byte_wdata", dmem_wdata, 32'h5A5A_5A5A);
        dmem_ready = 1'b1;
        cycle();

        // Half store at offset 2.
        dmem_ready = 1'b0;
        drive(1'b1, 32'h0000_2002, 3'd1, 32'h1234_BEEF);
        cycle();
        drive(1'b0, '0, '0, '0);
        check("half_wstrb", 32'(dmem_wstrb), 32'hC);
        check("half_wdata", dmem_wdata, 32'hBEEF_BEEF);
        dmem_ready = 1'b1;
        cycle();

        // Back-to-back misaligned stores.
        drive(1'b1, 32'h0000_3001, 3'd2, 32'h1111_1111);
        cycle();
        check("mis1_pulse", 32'(misalign), 32'h1);
        check("mis1_addr", misalign_addr, 32'h0000_3001);
        drive(1'b1, 32'h0000_3003, 3'd1, 32'h2222_2222);
        cycle();
        check("mis2_pulse", 32'(misalign), 32'h1);
        check("mis2_addr", misalign_addr, 32'h0000_3003);
        check("mis2_no_write", 32'(dmem_valid), 32'h0);
        drive(1'b0, '0, '0, '0);
        cycle();
        check("mis_pulse_end", 32'(misalign), 32'h0);

        // Full FIFO backpressure: third store stalls until one dequeue.
        dmem_ready = 1'b0;
        drive(1'b1, 32'h0000_4000, 3'd2, 32'hA000_0001);
        cycle();
        drive(1'b1, 32'h0000_4004, 3'd2, 32'hA000_0002);
        cycle();
        drive(1'b1, 32'h0000_4008, 3'd2, 32'hA000_0003);
        cycle();
        check("full_stall1", 32'(last_accept), 32'h0);
        check("full_head_stable", dmem_addr, 32'h0000_4000);
        cycle();
        check("full_stall2", 32'(last_accept), 32'h0);
        dmem_ready = 1'b1;
        cycle();
        check("full_stall3", 32'(last_accept), 32'h0);
        dmem_ready = 1'b0;
        cycle();
        check("full_third_accepted", 32'(last_accept), 32'h1);
        drive(1'b0, '0, '0, '0);
        dmem_ready = 1'b1;
        check("order_second", dmem_addr, 32'h0000_4004);
        cycle();
        check("order_third", dmem_addr, 32'h0000_4008);
        cycle();

        // Streaming: one write per cycle, count never above one.
        dmem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h0000_5000 + 32'(4 * i), 3'd2, 32'hC0DE_0000 + 32'(i));
            cycle();
            check("stream_pending", 32'(pending), 32'h1);
            check("stream_count_le1", 32'(dut.fifo_count <= 1), 32'h1);
        end
        drive(1'b0, '0, '0, '0);
        cycle();

        // Reset with two entries buffered.
        dmem_ready = 1'b0;
        drive(1'b1, 32'h0000_6000, 3'd2, 32'hDEAD_0001);
        cycle();
        drive(1'b1, 32'h0000_6004, 3'd2, 32'hDEAD_0002);
        cycle();
        check("pre_reset_count", 32'(dut.fifo_count), 32'h2);
        drive(1'b0, '0, '0, '0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("post_reset_valid", 32'(dmem_valid), 32'h0);
        check("post_reset_pending", 32'(pending), 32'h0);
        dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(63) == 0);
            dmem_ready = $urandom_range(1);
            drive($urandom_range(3) != 0,
                  {$urandom_range(32'hFFFF) << 16, 16'($urandom_range(16'hFFFF))},
                  3'($urandom_range(7)),
                  $urandom());
            cycle();
        end
        rst = 1'b0;
        drive(1'b0, '0, '0, '0);
        dmem_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
